calc_undo_core: RTL and testbench



---
 rtl/calc_undo_core_pkg.sv | 10 +
 rtl/calc_undo_core_if.sv | 20 ++
 rtl/calc_undo_core_undo_stack.sv | 42 ++++
 rtl/calc_undo_core.sv | 92 +++++++++
 tb/tb_calc_undo_core.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/calc_undo_core_pkg.sv
// Shared types for the calculator core: FSM state, ALU opcode, snapshot width.
package calc_pkg;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_OP, SHOW_RES} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_OR} op_t;

  // Snapshot packs {state, A, B, op}.
  function automatic int snap_w(int width);
    return 2 * width + 4;
  endfunction
endpackage

// File: rtl/calc_undo_core_if.sv
// Front-panel bus of the calculator core: button pulses and switches in, display/status out.
interface calc_undo_core_if #(
  parameter int WIDTH      = 16,
  parameter int UNDO_DEPTH = 4
);
  localparam int LW = $clog2(UNDO_DEPTH + 1);

  logic             enter;
  logic             undo;
  logic [WIDTH-1:0] sw;
  logic [WIDTH:0]   display;
  logic [1:0]       state;
  logic [LW-1:0]    undo_level;
  logic             result_valid;

  modport master (output enter, undo, sw,
                  input  display, state, undo_level, result_valid);
  modport slave  (input  enter, undo, sw,
                  output display, state, undo_level, result_valid);
endinterface

// File: rtl/calc_undo_core_undo_stack.sv
// Circular LIFO of snapshots: push overwrites the oldest entry when full, pop on empty is a no-op.
module undo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LW-1:0]     level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, top_ptr, nxt_ptr;

  assign top_ptr  = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
  assign nxt_ptr  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign data_out = mem[top_ptr];

  // When full, wr_ptr already points at the oldest entry, so a push simply overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      level  <= '0;
    end else if (pop) begin
      if (level != '0) begin
        wr_ptr <= top_ptr;
        level  <= level - 1'b1;
      end
    end else if (push) begin
      wr_ptr <= nxt_ptr;
      if (level != LW'(DEPTH)) level <= level + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/calc_undo_core.sv
// Calculator core: operand/op registers, inline ALU, entry FSM and undo history.
// Optional macro CALC_CHAIN_EN: enter in SHOW_RES chains the result into A.
module calc_undo_core
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int UNDO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  calc_undo_core_if.slave bus
);
  localparam int SNAP_W = snap_w(WIDTH);
  localparam int LW     = $clog2(UNDO_DEPTH + 1);

  state_t             st;
  op_t                op;
  logic [WIDTH-1:0]   a, b;
  logic [WIDTH:0]     res;
  logic [SNAP_W-1:0]  snap_in, snap_out;
  logic [LW-1:0]      level;
  logic               push;

  always_comb begin
    res = '0;
    case (op)
      OP_ADD: res = {1'b0, a} + {1'b0, b};
      OP_SUB: res = {1'b0, a} - {1'b0, b};
      OP_AND: res = {1'b0, a & b};
      OP_OR:  res = {1'b0, a | b};
      default: res = '0;
    endcase
  end

  // Undo takes priority, so a simultaneous enter neither pushes nor acts.
  assign push    = bus.enter & ~bus.undo;
  assign snap_in = {st, a, b, op};

  undo_stack #(.DATA_W(SNAP_W), .DEPTH(UNDO_DEPTH)) u_hist (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (bus.undo),
    .data_in  (snap_in),
    .data_out (snap_out),
    .level    (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= LOAD_A;
      a  <= '0;
      b  <= '0;
      op <= OP_ADD;
    end else if (bus.undo) begin
      if (level != '0) begin
        st <= state_t'(snap_out[SNAP_W-1 -: 2]);
        a  <= snap_out[2*WIDTH+1 -: WIDTH];
        b  <= snap_out[WIDTH+1 -: WIDTH];
        op <= op_t'(snap_out[1:0]);
      end
    end else if (bus.enter) begin
      case (st)
        LOAD_A: begin a <= bus.sw; st <= LOAD_B; end
        LOAD_B: begin b <= bus.sw; st <= LOAD_OP; end
        LOAD_OP: begin op <= op_t'(bus.sw[1:0]); st <= SHOW_RES; end
        SHOW_RES: begin
`ifdef CALC_CHAIN_EN
          a  <= res[WIDTH-1:0];
          st <= LOAD_B;
`else
          st <= LOAD_A;
`endif
        end
        default: st <= LOAD_A;
      endcase
    end
  end

  always_comb begin
    bus.display = {1'b0, bus.sw};
    case (st)
      LOAD_OP:  bus.display = {{(WIDTH-1){1'b0}}, bus.sw[1:0]};
      SHOW_RES: bus.display = res;
      default:  bus.display = {1'b0, bus.sw};
    endcase
  end

  assign bus.state        = st;
  assign bus.undo_level   = level;
  assign bus.result_valid = (st == SHOW_RES);
endmodule

// File: tb/tb_calc_undo_core.sv
// Self-checking bench for calc_undo_core: vector table, corner sequences and a random run against a queue model.
module tb_calc_undo_core;
  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_undo_core_if #(.WIDTH(W), .UNDO_DEPTH(D)) bus ();
  calc_undo_core #(.WIDTH(W), .UNDO_DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0, passed = 0;

  // Reference model: plain integers and a snapshot queue.
  typedef struct { int st; int a; int b; int op; } snap_t;
  snap_t hist[$];
  int m_st, m_a, m_b, m_op;
  int cur_sw;

  function automatic int alu();
    int r;
    case (m_op)
      0: r = m_a + m_b;
      1: begin r = m_a - m_b; if (r < 0) r += (1 << (W + 1)); end
      2: r = m_a & m_b;
      default: r = m_a | m_b;
    endcase
    return r;
  endfunction

  function automatic int exp_disp();
    case (m_st)
      2: return cur_sw & 3;
      3: return alu();
      default: return cur_sw;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    m_st = 0; m_a = 0; m_b = 0; m_op = 0;
  endtask

  task automatic model_step(input bit e, input bit u, input int s);
    snap_t t;
    if (u) begin
      if (hist.size() > 0) begin
        t = hist.pop_back();
        m_st = t.st; m_a = t.a; m_b = t.b; m_op = t.op;
      end
    end else if (e) begin
      hist.push_back('{m_st, m_a, m_b, m_op});
      if (hist.size() > D) void'(hist.pop_front());
      case (m_st)
        0: begin m_a = s; m_st = 1; end
        1: begin m_b = s; m_st = 2; end
        2: begin m_op = s & 3; m_st = 3; end
        default: begin
`ifdef CALC_CHAIN_EN
          m_a = alu() & ((1 << W) - 1);
          m_st = 1;
`else
          m_st = 0;
`endif
        end
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".display"}, 32'(bus.display), 32'(exp_disp()));
    chk({tag, ".state"}, 32'(bus.state), 32'(m_st));
    chk({tag, ".level"}, 32'(bus.undo_level), 32'(hist.size()));
    chk({tag, ".rv"}, 32'(bus.result_valid), 32'(m_st == 3));
  endtask

  task automatic step(input bit e, input bit u, input int s);
    @(negedge clk);
    bus.enter = e; bus.undo = u; bus.sw = W'(s); cur_sw = s & ((1 << W) - 1);
    model_step(e, u, cur_sw);
    @(posedge clk); #1;
    bus.enter = 1'b0; bus.undo = 1'b0;
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    reset = 1'b1; bus.enter = 1'b0; bus.undo = 1'b0; bus.sw = W'(s); cur_sw = s;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct { bit e; bit u; int sw; int st; int disp; int lvl; } vec_t;
  vec_t tbl[9];

  initial begin
    int prev_lvl, restores;
    bus.enter = 1'b0; bus.undo = 1'b0; bus.sw = '0; reset = 1'b0; cur_sw = 0;
    model_reset();

    // Add, then undo chain; expected values written from the arithmetic by hand.
    tbl[0] = '{1, 0, 16'h0005, 1, 'h00005, 1};
    tbl[1] = '{1, 0, 16'h0003, 2, 'h00003, 2};
    tbl[2] = '{1, 0, 16'h0000, 3, 'h00008, 3};
    tbl[3] = '{0, 1, 16'h0000, 2, 'h00000, 2};
    tbl[4] = '{1, 0, 16'h0001, 3, 'h00002, 3};
    tbl[5] = '{0, 1, 16'h0000, 2, 'h00000, 2};
    tbl[6] = '{0, 1, 16'h0000, 1, 'h00000, 1};
    tbl[7] = '{0, 1, 16'h0000, 0, 'h00000, 0};
    tbl[8] = '{0, 1, 16'h1234, 0, 'h01234, 0};

    do_reset(16'h00A5);
    chk("reset.display", 32'(bus.display), 32'h000A5);
    chk("reset.state", 32'(bus.state), 0);
    chk("reset.level", 32'(bus.undo_level), 0);
    chk("reset.rv", 32'(bus.result_valid), 0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].e, tbl[i].u, tbl[i].sw);
      chk($sformatf("tbl%0d.state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d.display", i), 32'(bus.display), 32'(tbl[i].disp));
      chk($sformatf("tbl%0d.level", i), 32'(bus.undo_level), 32'(tbl[i].lvl));
    end

    // Subtract with borrow.
    do_reset(0);
    step(1, 0, 2); step(1, 0, 5); step(1, 0, 1);
    chk("sub.display", 32'(bus.display), 32'h1FFFD);
    chk("sub.borrow", 32'(bus.display[W]), 1);

    // Enter in SHOW_RES after an add.
    do_reset(0);
    step(1, 0, 5); step(1, 0, 3); step(1, 0, 0);
    step(1, 0, 0);
`ifdef CALC_CHAIN_EN
    chk("chain.state", 32'(bus.state), 1);
    chk("chain.a", 32'(dut.a), 32'h0008);
    step(1, 0, 2); step(1, 0, 0);
    chk("chain.display", 32'(bus.display), 32'h0000A);
`else
    chk("nochain.state", 32'(bus.state), 0);
    step(0, 1, 0);
    chk("nochain.undo_state", 32'(bus.state), 3);
    chk("nochain.undo_display", 32'(bus.display), 32'h00008);
`endif
    chk_model("chain");

    // History overflow: six pushes, five undos, only four restores.
    do_reset(0);
    for (int i = 1; i <= 6; i++) step(1, 0, i);
    chk("ovf.level", 32'(bus.undo_level), 4);
    restores = 0;
    for (int i = 0; i < 5; i++) begin
      prev_lvl = int'(bus.undo_level);
      step(0, 1, 0);
      chk_model($sformatf("ovf_undo%0d", i));
      if (int'(bus.undo_level) < prev_lvl) restores++;
    end
    chk("ovf.restores", 32'(restores), 4);
    chk("ovf.final_level", 32'(bus.undo_level), 0);
    chk("ovf.final_state", 32'(bus.state), 32'(m_st));

    // Simultaneous enter+undo in LOAD_B with one snapshot.
    do_reset(0);
    step(1, 0, 7);
    step(1, 1, 9);
    chk("sim.state", 32'(bus.state), 0);
    chk("sim.level", 32'(bus.undo_level), 0);
    chk("sim.display", 32'(bus.display), 32'h00009);
    chk("sim.a", 32'(dut.a), 0);
    chk("sim.b", 32'(dut.b), 0);

    // Reset mid-sequence.
    step(1, 0, 5); step(1, 0, 6);
    do_reset(16'h0ABC);
    chk("midrst.display", 32'(bus.display), 32'h00ABC);
    chk("midrst.state", 32'(bus.state), 0);
    chk("midrst.level", 32'(bus.undo_level), 0);
    chk("midrst.rv", 32'(bus.result_valid), 0);

    // Random run against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        do_reset(int'($urandom_range(16'hFFFF)));
        chk_model($sformatf("rnd%0d_rst", i));
      end else begin
        step(1'($urandom_range(1)), ($urandom_range(4) == 0), int'($urandom_range(16'hFFFF)));
        chk_model($sformatf("rnd%0d", i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
